alu_logic_issuer: RTL and testbench
===================================

Name: alu_logic_issuer

Overview:
- Initiator side of the clocked OR/NOR function-unit interface in the 16-bit ALU.
- Accepts a logic-op command over a valid/ready handshake and drives registered operands to the OR and NOR units.
- Waits out the units' registered latency, captures the selected result, and returns it over a second valid/ready handshake.
- Sits between the ALU control path and the logic function units.

Parameters:
- WIDTH, 16, operand/result width; must match the function units.
- LAT, 1, function-unit latency in clk edges from stable operands to stable output; legal range 1..15.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  issuer can accept a command.
- cmd_a  in  WIDTH  operand A.
- cmd_b  in  WIDTH  operand B.
- cmd_op  in  1  0 = OR, 1 = NOR.
- alu_a  out  WIDTH  registered operand A to both function units.
- alu_b  out  WIDTH  registered operand B to both function units.
- or_result  in  WIDTH  OR unit output.
- nor_result  in  WIDTH  NOR unit output.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  captured result.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- States: IDLE, WAIT, DONE; 4-bit down-counter cnt; 1-bit op_q; WIDTH-bit res_q.
- Reset (rst=1 at posedge, any state): state=IDLE, cnt=0, op_q=0, alu_a=0, alu_b=0, res_data=0, res_valid=0, busy=0, cmd_ready=1 after the edge.
- Reset mid-operation: any in-flight command is dropped and no result is produced.
- cmd_ready = (state==IDLE), combinational from state only, never from cmd_valid.
- IDLE: on an edge with cmd_valid=1, the command is accepted.
  - Actions: alu_a<=cmd_a, alu_b<=cmd_b, op_q<=cmd_op, cnt<=LAT, go to WAIT.
  - With cmd_valid=0 the issuer stays in IDLE.
- WAIT:
  - alu_a and alu_b are held stable for the entire state.
  - If cnt!=0: cnt<=cnt-1 and stay in WAIT.
  - If cnt==0: res_q<=(op_q ? nor_result : or_result), res_valid<=1, go to DONE.
  - cmd_valid is ignored; the requester holds its command because cmd_ready=0.
- Latency: accept at edge E0, capture at edge E(LAT+1). res_valid is first high in the cycle after E(LAT+1).
- DONE:
  - res_data=res_q and res_valid=1 hold stable until an edge with res_ready=1.
  - On that edge: res_valid<=0, go to IDLE.
  - cmd_ready is 0 throughout DONE, including the handshake cycle. No accept occurs on the DONE→IDLE edge.
- Throughput: one command every LAT+3 cycles when res_ready is tied high.
- res_data keeps its last captured value after returning to IDLE; it changes only at capture or reset.
- alu_a and alu_b keep their last operands in IDLE and DONE. They change only on accept or reset.
- res_ready while res_valid=0 has no effect.
- Width: bitwise ops only; no carry, no extension.

Optional Feature:
- Macro: ALU_LOGIC_FLAGS_EN.
- When defined, two outputs are added after res_data:
  - res_zero  out  1  (captured result == 0).
  - res_neg  out  1  (captured result MSB).
- Both flags are registered at the same edge as res_q, reset to 0, and hold with res_data.
- When not defined, the ports and logic are absent; all other behaviour is identical.

Test Plan:
- Reset: assert rst for 2 cycles mid-WAIT after accepting a=0x1234 → cmd_ready=1, res_valid=0, alu_a=alu_b=res_data=0; no result ever appears for that command.
- OR, LAT=1: a=0x00F0, b=0x0F00, op=0, res_ready=1 → res_valid high 2 edges after accept, res_data=0x0FF0, busy high from accept until return to IDLE.
- NOR: a=0x00F0, b=0x0F00, op=1 → res_data=0xF00F. With ALU_LOGIC_FLAGS_EN: res_zero=0, res_neg=1.
- Backpressure: a=0xFFFF, b=0x0000, op=1, res_ready=0 for 5 cycles → res_valid and res_data=0x0000 held stable, cmd_ready=0; with flags res_zero=1. Raising res_ready → IDLE on the next edge.
- Back-to-back: cmd_valid held high with two queued commands (0x0001|0x0002, then NOR 0xAAAA,0x5555) and res_ready=1 → results 0x0003 then 0x0000; accepts spaced LAT+3 cycles apart.
- Command during WAIT: change cmd_a while cmd_ready=0 → alu_a unchanged until the next IDLE accept.

Source files
------------

// File: rtl/alu_logic_issuer.sv
// alu_logic_issuer: initiator for the clocked OR/NOR function units of the
// 16-bit ALU. It accepts one logic-op command, drives registered operands to
// both units, waits out their latency, captures the selected result and
// returns it to the consumer.
//
// Optional feature: define ALU_LOGIC_FLAGS_EN to add the res_zero / res_neg
// result flags, which are captured together with res_data.
//
// Handshake rule (both ports): a transfer happens on a posedge where valid
// and ready are both high. A valid source holds its payload until that edge.
// cmd_ready depends on state only and never on cmd_valid.
module alu_logic_issuer #(
  parameter int WIDTH = 16,
  parameter int LAT   = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic             cmd_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] or_result,
  input  logic [WIDTH-1:0] nor_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
`ifdef ALU_LOGIC_FLAGS_EN
  output logic             res_zero,
  output logic             res_neg,
`endif
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             op_q, op_d;
  logic [WIDTH-1:0] alu_a_q, alu_a_d;
  logic [WIDTH-1:0] alu_b_q, alu_b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             res_valid_q, res_valid_d;
  logic [WIDTH-1:0] sel_result;

  // Result chosen by the latched opcode; only sampled when cnt reaches zero.
  assign sel_result = op_q ? nor_result : or_result;

  // Next-state logic: accept in IDLE, count down in WAIT, hold in DONE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          alu_a_d = cmd_a;
          alu_b_d = cmd_b;
          op_d    = cmd_op;
          cnt_d   = 4'(LAT);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          res_d       = sel_result;
          res_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: begin
        state_d     = IDLE;
        res_valid_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous reset; reset drops any in-flight command.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      op_q        <= 1'b0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
    end
  end

`ifdef ALU_LOGIC_FLAGS_EN
  logic res_zero_q, res_zero_d;
  logic res_neg_q, res_neg_d;

  // Flags are captured on the same edge as res_q and held with it.
  always_comb begin
    res_zero_d = res_zero_q;
    res_neg_d  = res_neg_q;
    if (state_q == WAIT && cnt_q == 4'd0) begin
      res_zero_d = (sel_result == '0);
      res_neg_d  = sel_result[WIDTH-1];
    end
  end

  // Flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      res_zero_q <= 1'b0;
      res_neg_q  <= 1'b0;
    end else begin
      res_zero_q <= res_zero_d;
      res_neg_q  <= res_neg_d;
    end
  end

  assign res_zero = res_zero_q;
  assign res_neg  = res_neg_q;
`endif

  assign cmd_ready = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign res_valid = res_valid_q;
  assign res_data  = res_q;

endmodule

// File: tb/tb_alu_logic_issuer.sv
// Directed testbench for alu_logic_issuer. Models the OR/NOR units as a
// LAT-deep register pipeline, checks latency, hold behaviour, backpressure,
// back-to-back spacing and mid-operation reset.
module tb_alu_logic_issuer;
  localparam int WIDTH = 16;
  localparam int LAT   = 1;

  logic             clk;
  logic             rst;
  logic             cmd_valid;
  logic             cmd_ready;
  logic [WIDTH-1:0] cmd_a;
  logic [WIDTH-1:0] cmd_b;
  logic             cmd_op;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] or_result;
  logic [WIDTH-1:0] nor_result;
  logic             res_valid;
  logic             res_ready;
  logic [WIDTH-1:0] res_data;
`ifdef ALU_LOGIC_FLAGS_EN
  logic             res_zero;
  logic             res_neg;
`endif
  logic             busy;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [WIDTH-1:0] exp_q[$];

  alu_logic_issuer #(.WIDTH(WIDTH), .LAT(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .or_result  (or_result),
    .nor_result (nor_result),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .res_data   (res_data),
`ifdef ALU_LOGIC_FLAGS_EN
    .res_zero   (res_zero),
    .res_neg    (res_neg),
`endif
    .busy       (busy)
  );

  // Clock and cycle counter.
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Function-unit model: LAT register stages from operands to results.
  logic [WIDTH-1:0] or_pipe  [LAT];
  logic [WIDTH-1:0] nor_pipe [LAT];
  always @(posedge clk) begin
    or_pipe[0]  <= alu_a | alu_b;
    nor_pipe[0] <= ~(alu_a | alu_b);
    for (int i = 1; i < LAT; i++) begin
      or_pipe[i]  <= or_pipe[i-1];
      nor_pipe[i] <= nor_pipe[i-1];
    end
  end
  assign or_result  = or_pipe[LAT-1];
  assign nor_result = nor_pipe[LAT-1];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge in IDLE; returns at the negedge after the accept edge.
  task automatic issue(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic op);
    cmd_valid = 1'b1;
    cmd_a     = a;
    cmd_b     = b;
    cmd_op    = op;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  // Counts negedges until res_valid, bounded.
  task automatic wait_res(output int n);
    n = 0;
    while (!res_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic expect_res(input string tag);
    logic [WIDTH-1:0] e;
    if (exp_q.size() == 0) begin
      chk({tag, "_noexp"}, 32'd1, 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk(tag, 32'(res_data), 32'(e));
    end
  endtask

  int n;
  int t0;
  int t1;
  logic seen;

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    cmd_op    = 1'b0;
    res_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state.
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_res_valid", 32'(res_valid), 32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    chk("rst_alu_a",     32'(alu_a),     32'd0);
    chk("rst_alu_b",     32'(alu_b),     32'd0);
    chk("rst_res_data",  32'(res_data),  32'd0);

    // OR.
    exp_q.push_back(16'h0FF0);
    issue(16'h00F0, 16'h0F00, 1'b0);
    chk("or_busy",      32'(busy),      32'd1);
    chk("or_cmd_ready", 32'(cmd_ready), 32'd0);
    chk("or_alu_a",     32'(alu_a),     32'h00F0);
    chk("or_alu_b",     32'(alu_b),     32'h0F00);
    wait_res(n);
    chk("or_latency", 32'(n), 32'(LAT + 1));
    expect_res("or_data");
    chk("or_busy_done", 32'(busy), 32'd1);
`ifdef ALU_LOGIC_FLAGS_EN
    chk("or_zero", 32'(res_zero), 32'd0);
    chk("or_neg",  32'(res_neg),  32'd0);
`endif
    @(negedge clk);
    chk("or_idle_ready", 32'(cmd_ready), 32'd1);
    chk("or_idle_busy",  32'(busy),      32'd0);
    chk("or_idle_valid", 32'(res_valid), 32'd0);
    chk("or_data_hold",  32'(res_data),  32'h0FF0);

    // NOR.
    exp_q.push_back(16'hF00F);
    issue(16'h00F0, 16'h0F00, 1'b1);
    wait_res(n);
    chk("nor_latency", 32'(n), 32'(LAT + 1));
    expect_res("nor_data");
`ifdef ALU_LOGIC_FLAGS_EN
    chk("nor_zero", 32'(res_zero), 32'd0);
    chk("nor_neg",  32'(res_neg),  32'd1);
`endif
    @(negedge clk);

    // Backpressure, with a competing command presented during DONE.
    res_ready = 1'b0;
    exp_q.push_back(16'h0000);
    issue(16'hFFFF, 16'h0000, 1'b1);
    wait_res(n);
    chk("bp_latency", 32'(n), 32'(LAT + 1));
    expect_res("bp_data");
    cmd_valid = 1'b1;
    cmd_a     = 16'h5A5A;
    cmd_b     = 16'h0000;
    cmd_op    = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid_hold", 32'(res_valid), 32'd1);
      chk("bp_data_hold",  32'(res_data),  32'h0000);
      chk("bp_cmd_ready",  32'(cmd_ready), 32'd0);
    end
`ifdef ALU_LOGIC_FLAGS_EN
    chk("bp_zero", 32'(res_zero), 32'd1);
    chk("bp_neg",  32'(res_neg),  32'd0);
`endif
    res_ready = 1'b1;
    @(negedge clk);
    chk("bp_release_ready", 32'(cmd_ready), 32'd1);
    chk("bp_release_valid", 32'(res_valid), 32'd0);
    chk("bp_no_accept",     32'(alu_a),     32'hFFFF);
    // Let the pending 0x5A5A command go through.
    exp_q.push_back(16'h5A5A);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("bp_next_alu_a", 32'(alu_a), 32'h5A5A);
    wait_res(n);
    expect_res("bp_next_data");
    @(negedge clk);

    // Back-to-back with cmd_valid held high.
    cmd_valid = 1'b1;
    cmd_a     = 16'h0001;
    cmd_b     = 16'h0002;
    cmd_op    = 1'b0;
    exp_q.push_back(16'h0003);
    exp_q.push_back(16'h0000);
    t0 = cyc + 1;
    @(posedge clk);
    @(negedge clk);
    cmd_a  = 16'hAAAA;
    cmd_b  = 16'h5555;
    cmd_op = 1'b1;
    wait_res(n);
    expect_res("b2b_first");
    n = 0;
    while (!cmd_ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    t1 = cyc + 1;
    chk("b2b_spacing", 32'(t1 - t0), 32'(LAT + 3));
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    wait_res(n);
    expect_res("b2b_second");
    @(negedge clk);

    // Command changes while WAIT/DONE: operands stay until the next accept.
    exp_q.push_back(16'h1111);
    exp_q.push_back(16'h2222);
    issue(16'h1111, 16'h0000, 1'b0);
    cmd_valid = 1'b1;
    cmd_a     = 16'h2222;
    chk("wait_alu_a_hold", 32'(alu_a), 32'h1111);
    wait_res(n);
    expect_res("wait_first");
    chk("done_alu_a_hold", 32'(alu_a), 32'h1111);
    @(negedge clk);
    chk("idle_alu_a_hold", 32'(alu_a), 32'h1111);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    chk("wait_alu_a_new", 32'(alu_a), 32'h2222);
    wait_res(n);
    expect_res("wait_second");
    @(negedge clk);

    // Reset in the middle of WAIT.
    issue(16'h1234, 16'h0000, 1'b0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("mrst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("mrst_res_valid", 32'(res_valid), 32'd0);
    chk("mrst_alu_a",     32'(alu_a),     32'd0);
    chk("mrst_alu_b",     32'(alu_b),     32'd0);
    chk("mrst_res_data",  32'(res_data),  32'd0);
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      seen = seen | res_valid;
    end
    chk("mrst_no_result", 32'(seen), 32'd0);
    chk("exp_q_empty", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
